// File: rtl/simon_host_ctrl_if.sv
// Byte-wide host command/response bundle between the I/O pins and simon_host_ctrl.
// Requests flow master->slave on cmd_*, and ciphertext bytes flow slave->master on rsp_*.
interface simon_host_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_last;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/simon_host_ctrl.sv
// Host-side sequencer for a bit-serial Simon 32/64 core: serialises load/encrypt commands,
// collects the serial ciphertext into a block buffer and returns it as bytes.
module simon_host_ctrl #(
    parameter int BLOCK_BITS = 32,
    parameter int MAX_WAIT   = 1023
) (
    input  logic                clk,
    input  logic                reset,
    simon_host_ctrl_if.slave    host,
    output logic                core_data_in,
    output logic [1:0]          core_data_rdy,
    input  logic                core_cipher_out,
    input  logic                core_valid,
    output logic                busy,
    output logic                timeout
);

    localparam int NBYTES = BLOCK_BITS / 8;
    // The bit counter also walks the 8 bits of a load byte, so it is never narrower than 3 bits.
    localparam int BIT_W  = (BLOCK_BITS > 8) ? $clog2(BLOCK_BITS) : 3;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int WD_W   = $clog2(MAX_WAIT + 1);

    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(BLOCK_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_SHIFT = BIT_W'(7);
    localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(NBYTES - 1);
    localparam logic [WD_W-1:0]   WD_MAX     = WD_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT,
        COLLECT,
        DRAIN
    } state_t;

    state_t                state, state_n;
    logic [1:0]            op_q, op_n;
    logic [7:0]            byte_q, byte_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [BYTE_W-1:0]     byte_cnt, byte_cnt_n;
    logic [WD_W-1:0]       wdog, wdog_n;
    logic [BLOCK_BITS-1:0] blk, blk_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            byte_q   <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            wdog     <= '0;
            blk      <= '0;
        end else begin
            state    <= state_n;
            op_q     <= op_n;
            byte_q   <= byte_n;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            wdog     <= wdog_n;
            blk      <= blk_n;
        end
    end

    // Outputs decode only registered state; reset gating keeps every output low while reset is held.
    always_comb begin
        state_n        = state;
        op_n           = op_q;
        byte_n         = byte_q;
        bit_cnt_n      = bit_cnt;
        byte_cnt_n     = byte_cnt;
        wdog_n         = wdog;
        blk_n          = blk;
        host.cmd_ready = 1'b0;
        host.rsp_valid = 1'b0;
        host.rsp_data  = '0;
        host.rsp_last  = 1'b0;
        core_data_in   = 1'b0;
        core_data_rdy  = 2'd0;
        busy           = 1'b0;
        timeout        = 1'b0;

        unique case (state)
            IDLE: begin
                if (host.cmd_valid) begin
                    unique case (host.cmd_op)
                        2'd1, 2'd2: begin
                            op_n      = host.cmd_op;
                            byte_n    = host.cmd_data;
                            bit_cnt_n = '0;
                            state_n   = SHIFT;
                        end
                        2'd3: begin
                            wdog_n    = '0;
                            bit_cnt_n = '0;
                            state_n   = WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                core_data_rdy = op_q;
                core_data_in  = byte_q[bit_cnt[2:0]];
                if (bit_cnt == LAST_SHIFT) begin
                    bit_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            WAIT: begin
                core_data_rdy = 2'd3;
                // The abort is checked before incrementing, so the watchdog saturates at MAX_WAIT.
                if (wdog == WD_MAX) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end else begin
                    wdog_n = wdog + 1'b1;
                    if (core_valid) begin
                        blk_n[0]  = core_cipher_out;
                        bit_cnt_n = BIT_W'(1);
                        state_n   = COLLECT;
                    end
                end
            end
            COLLECT: begin
                core_data_rdy = 2'd3;
                if (core_valid) begin
                    blk_n[bit_cnt] = core_cipher_out;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n  = '0;
                        byte_cnt_n = '0;
                        state_n    = DRAIN;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                host.rsp_valid = 1'b1;
                host.rsp_data  = blk[{byte_cnt, 3'b000} +: 8];
                host.rsp_last  = (byte_cnt == LAST_BYTE);
                if (host.rsp_ready) begin
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_n = '0;
                        state_n    = IDLE;
                    end else begin
                        byte_cnt_n = byte_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        host.cmd_ready = (state == IDLE);
        busy           = (state != IDLE);

        if (reset) begin
            host.cmd_ready = 1'b0;
            host.rsp_valid = 1'b0;
            host.rsp_data  = '0;
            host.rsp_last  = 1'b0;
            core_data_in   = 1'b0;
            core_data_rdy  = 2'd0;
            busy           = 1'b0;
            timeout        = 1'b0;
        end
    end

endmodule

// File: tb/tb_simon_host_ctrl.sv
// Bench for simon_host_ctrl: table-driven byte loads plus hand-written encrypt, stall,
// watchdog and reset sequences against a behavioural Simon 32/64 core model.
module tb_simon_host_ctrl;

    localparam int BLOCK_BITS = 32;
    localparam int MAX_WAIT   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_data_in;
    logic [1:0] core_data_rdy;
    logic       core_cipher_out;
    logic       core_valid;
    logic       busy;
    logic       timeout;

    simon_host_ctrl_if bus ();

    simon_host_ctrl #(
        .BLOCK_BITS (BLOCK_BITS),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .host            (bus.slave),
        .core_data_in    (core_data_in),
        .core_data_rdy   (core_data_rdy),
        .core_cipher_out (core_cipher_out),
        .core_valid      (core_valid),
        .busy            (busy),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Core model controls
    bit          never_valid = 1'b0;
    int          model_lat   = 2;
    int          gap_at      = -1;
    int          gap_len     = 0;
    logic [31:0] pt_reg      = '0;
    logic [63:0] key_reg     = '0;

    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [31:0] simon32(input logic [31:0] pt, input logic [63:0] key);
        logic [15:0] k [0:31];
        logic [15:0] x, y, tmp;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp  = ror(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ ror(tmp, 1);
            k[i] = 16'hFFFC ^ k[i-4] ^ tmp ^ {15'b0, z[61-(i-4)]};
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    // Behavioural core: shifts loads in LSB first, then streams Simon(pt,key) LSB first.
    initial begin : core_model
        bit          enc_active;
        int          wait_cnt, bit_idx, gap_left;
        logic [31:0] ct;
        logic        nv, nb;
        enc_active      = 1'b0;
        wait_cnt        = 0;
        bit_idx         = 0;
        gap_left        = 0;
        ct              = '0;
        core_valid      = 1'b0;
        core_cipher_out = 1'b0;
        forever begin
            @(posedge clk);
            nv = 1'b0;
            nb = 1'b0;
            if (reset) begin
                enc_active = 1'b0;
            end else begin
                if (core_data_rdy == 2'd1) pt_reg  = {core_data_in, pt_reg[31:1]};
                if (core_data_rdy == 2'd2) key_reg = {core_data_in, key_reg[63:1]};
                if (core_data_rdy == 2'd3) begin
                    if (!enc_active) begin
                        enc_active = 1'b1;
                        ct         = simon32(pt_reg, key_reg);
                        wait_cnt   = 0;
                        bit_idx    = 0;
                        gap_left   = gap_len;
                    end
                    if (!never_valid && bit_idx < 32) begin
                        if (wait_cnt < model_lat) wait_cnt++;
                        else if (bit_idx == gap_at && gap_left > 0) gap_left--;
                        else begin
                            nv = 1'b1;
                            nb = ct[bit_idx];
                            bit_idx++;
                        end
                    end
                end else begin
                    enc_active = 1'b0;
                end
            end
            #1;
            core_valid      = nv;
            core_cipher_out = nb;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    // Presents a command, waits (bounded) for cmd_ready, and returns one cycle after the handshake.
    task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] data);
        int guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        while (bus.cmd_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check_output("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        else tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 8'h00;
    endtask

    task automatic load_block(input logic [31:0] pt, input logic [63:0] key);
        for (int b = 0; b < 4; b++) apply_stimulus(2'd1, pt[8*b +: 8]);
        for (int b = 0; b < 8; b++) apply_stimulus(2'd2, key[8*b +: 8]);
    endtask

    task automatic wait_rsp(input int exp_cycles);
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check_output("rsp_valid_latency", 32'(n), 32'(exp_cycles));
    endtask

    task automatic drain_block(input logic [31:0] exp, input int stall_k, input int stall_len);
        for (int k = 0; k < 4; k++) begin
            if (k == stall_k) begin
                bus.rsp_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check_output("stall_valid", 32'(bus.rsp_valid), 32'd1);
                    check_output("stall_data", 32'(bus.rsp_data), 32'(exp[8*k +: 8]));
                    tick();
                end
            end
            bus.rsp_ready = 1'b1;
            check_output("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check_output("rsp_data", 32'(bus.rsp_data), 32'(exp[8*k +: 8]));
            check_output("rsp_last", 32'(bus.rsp_last), (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b0;
        check_output("post_drain_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("post_drain_ready", 32'(bus.cmd_ready), 32'd1);
        check_output("post_drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_idle_after_reset(input string tag);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_core_rdy"}, 32'(core_data_rdy), 32'd0);
        check_output({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check_output({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        apply_stimulus(2'd0, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            check_output({tag, "_nop_busy"}, 32'(busy), 32'd0);
            check_output({tag, "_nop_core"}, {29'd0, core_data_rdy, core_data_in}, 32'd0);
            check_output({tag, "_nop_ready"}, 32'(bus.cmd_ready), 32'd1);
            tick();
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [0:7] exp_seq;
    } load_vec_t;

    initial begin : watchdog_guard
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global time limit reached");
    end

    initial begin : main
        load_vec_t   lv [4];
        logic [31:0] exp_ct;
        lv[0] = '{2'd1, 8'hA5, 8'b10100101};
        lv[1] = '{2'd2, 8'h0B, 8'b11010000};
        lv[2] = '{2'd1, 8'h80, 8'b00000001};
        lv[3] = '{2'd2, 8'hFE, 8'b01111111};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        reset         = 1'b1;

        // Reset: all outputs low while held, cmd_ready the cycle after release
        for (int c = 0; c < 3; c++) begin
            tick();
            check_output("reset_outputs",
                {19'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_last, busy, timeout,
                 core_data_in, core_data_rdy, bus.rsp_data}, 32'd0);
        end
        reset = 1'b0;
        tick();
        check_output("release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_output("release_busy", 32'(busy), 32'd0);

        // Byte loads from the table
        for (int v = 0; v < 4; v++) begin
            apply_stimulus(lv[v].op, lv[v].data);
            for (int c = 0; c < 8; c++) begin
                check_output("shift_rdy", 32'(core_data_rdy), 32'(lv[v].op));
                check_output("shift_bit", 32'(core_data_in), 32'(lv[v].exp_seq[c]));
                check_output("shift_cmd_ready", 32'(bus.cmd_ready), 32'd0);
                tick();
            end
            check_output("shift_done_ready", 32'(bus.cmd_ready), 32'd1);
            check_output("shift_done_core", {29'd0, core_data_rdy, core_data_in}, 32'd0);
        end

        // Full encrypt with the plaintext bytes in host order, no stalls
        model_lat = 2;
        load_block(32'h77686565, 64'h1918111009080100);
        exp_ct = simon32(32'h77686565, 64'h1918111009080100);
        apply_stimulus(2'd3, 8'h00);
        check_output("enc_core_rdy", 32'(core_data_rdy), 32'd3);
        check_output("enc_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        wait_rsp(33 + model_lat);
        drain_block(exp_ct, -1, 0);

        // Published vector with core_valid gaps and a 5-cycle rsp_ready stall on byte 2
        gap_at  = 10;
        gap_len = 2;
        load_block(32'h65656877, 64'h1918111009080100);
        apply_stimulus(2'd3, 8'h00);
        wait_rsp(33 + model_lat + 2);
        drain_block(32'hC69BE9BB, 1, 5);
        gap_at  = -1;
        gap_len = 0;

        // Watchdog: core never answers
        never_valid = 1'b1;
        apply_stimulus(2'd3, 8'h00);
        for (int i = 1; i <= MAX_WAIT; i++) begin
            check_output("wd_no_timeout", 32'(timeout), 32'd0);
            check_output("wd_no_rsp", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        check_output("wd_timeout_pulse", 32'(timeout), 32'd1);
        tick();
        check_output("wd_timeout_clear", 32'(timeout), 32'd0);
        check_output("wd_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_output("wd_rsp_after", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        never_valid = 1'b0;

        // Reset at cycle 4 of SHIFT
        apply_stimulus(2'd1, 8'h5A);
        tick();
        tick();
        tick();
        check_idle_after_reset("rst_shift");

        // Reset during DRAIN, after the first byte is taken
        load_block(32'h65656877, 64'h1918111009080100);
        apply_stimulus(2'd3, 8'h00);
        wait_rsp(33 + model_lat);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_idle_after_reset("rst_drain");

        // A fresh encrypt after the aborted drain restarts at byte 0
        apply_stimulus(2'd3, 8'h00);
        wait_rsp(33 + model_lat);
        drain_block(32'hC69BE9BB, 3, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
